// File: rtl/mc6809e_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mc6809e_bus_arbiter
//
// Clock-enable generator and DMA bus arbiter placed beside the MC6809E core.
// A free-running phase generator produces the E/Q falling-edge strobes. The
// arbiter shares the CPU bus between the core and two DMA requesters: it halts
// the CPU (nHALT low), waits for the halt acknowledge (BA=1, BS=1), grants one
// requester round-robin, and afterwards hands the bus back to the CPU for at
// least one E period.
//
// Parameters
//   QDIV       CLK_ROOT cycles per quarter E phase (>=1); E = 4*QDIV cycles.
//   MAX_GRANT  grant watchdog limit in E periods (ARB_WATCHDOG_EN only).
//
// Ports
//   CLK_ROOT     in   system clock, rising edge
//   RESET        in   asynchronous, active-high reset
//   CE_E_FALL    out  one-cycle strobe marking E falling
//   CE_Q_FALL    out  one-cycle strobe, QDIV cycles before CE_E_FALL
//   BA, BS       in   CPU bus available / bus status
//   nHALT        out  active-low halt request to the CPU
//   REQ[1:0]     in   DMA requests, level, active-high
//   GNT[1:0]     out  grants, one-hot or zero
//   TIMEOUT      out  one-cycle pulse when the watchdog revokes a grant
//   o_dbg_state  out  arbiter FSM state (debug)
//
// Build option
//   ARB_WATCHDOG_EN  when defined, a grant is revoked after MAX_GRANT E periods
//                    and TIMEOUT pulses; otherwise TIMEOUT is tied low.
//
// Handshake: REQ is a level; a requester keeps REQ high for as long as it
// wants the bus and owns the bus while its GNT bit is high. Dropping REQ ends
// the grant at the next E falling edge. All arbiter outputs are registered and
// only change on the CLK_ROOT edge that ends a CE_E_FALL cycle.
// -----------------------------------------------------------------------------
module mc6809e_bus_arbiter #(
  parameter int QDIV      = 4,
  parameter int MAX_GRANT = 64
) (
  input  logic       CLK_ROOT,
  input  logic       RESET,
  output logic       CE_E_FALL,
  output logic       CE_Q_FALL,
  input  logic       BA,
  input  logic       BS,
  output logic       nHALT,
  input  logic [1:0] REQ,
  output logic [1:0] GNT,
  output logic       TIMEOUT,
  output logic [1:0] o_dbg_state
);

  localparam int SUB_W = (QDIV > 1) ? $clog2(QDIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_GRANT    = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Parameter sanity: these blocks elaborate to nothing for legal values.
  if (QDIV < 1) begin : g_qdiv_illegal
  end
  if (MAX_GRANT < 1) begin : g_max_grant_illegal
  end

  // ---------------------------------------------------------------------------
  // Phase generator
  // ---------------------------------------------------------------------------
  logic [SUB_W-1:0] r_sub;
  logic [1:0]       r_quarter;
  logic             w_sub_last;

  assign w_sub_last = (r_sub == SUB_W'(QDIV - 1));

  always_ff @(posedge CLK_ROOT or posedge RESET) begin
    if (RESET) begin
      r_sub     <= '0;
      r_quarter <= 2'd0;
    end else if (w_sub_last) begin
      r_sub     <= '0;
      r_quarter <= r_quarter + 2'd1;
    end else begin
      r_sub     <= r_sub + SUB_W'(1);
    end
  end

  // Decodes of registered counters on different quarters: never coincident.
  assign CE_Q_FALL = w_sub_last && (r_quarter == 2'd2);
  assign CE_E_FALL = w_sub_last && (r_quarter == 2'd3);

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  state_t     r_state,  w_state_nxt;
  logic       r_nhalt,  w_nhalt_nxt;
  logic [1:0] r_gnt,    w_gnt_nxt;
  logic       r_last,   w_last_nxt;    // requester granted most recently
  logic       r_winner, w_winner_nxt;  // requester chosen in IDLE

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_GRANT + 1);
  logic [WD_W-1:0] r_wd_cnt, w_wd_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
`endif

  always_ff @(posedge CLK_ROOT or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_nhalt   <= 1'b1;
      r_gnt     <= 2'b00;
      r_last    <= 1'b1;   // REQ[0] wins the first contention after reset
      r_winner  <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_nhalt   <= w_nhalt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_last    <= w_last_nxt;
      r_winner  <= w_winner_nxt;
`ifdef ARB_WATCHDOG_EN
      r_wd_cnt  <= w_wd_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_nhalt_nxt   = r_nhalt;
    w_gnt_nxt     = r_gnt;
    w_last_nxt    = r_last;
    w_winner_nxt  = r_winner;
`ifdef ARB_WATCHDOG_EN
    w_wd_cnt_nxt  = r_wd_cnt;
    w_timeout_nxt = 1'b0;  // pulse lasts only the cycle after the revoking edge
`endif

    if (CE_E_FALL) begin
      case (r_state)
        ST_IDLE: begin
          w_nhalt_nxt = 1'b1;
          w_gnt_nxt   = 2'b00;
          if (REQ != 2'b00) begin
            // Under contention the requester not served last wins.
            w_winner_nxt = (REQ == 2'b11) ? ~r_last : REQ[1];
            w_nhalt_nxt  = 1'b0;
            w_state_nxt  = ST_HALT_REQ;
          end
        end

        ST_HALT_REQ: begin
          if (BA && BS) begin
            if (REQ[r_winner]) begin
              w_gnt_nxt   = r_winner ? 2'b10 : 2'b01;
              w_last_nxt  = r_winner;
              w_state_nxt = ST_GRANT;
`ifdef ARB_WATCHDOG_EN
              w_wd_cnt_nxt = '0;
`endif
            end else begin
              // Request withdrawn while halting: give the bus straight back.
              w_nhalt_nxt = 1'b1;
              w_state_nxt = ST_RELEASE;
            end
          end
        end

        ST_GRANT: begin
          if (!REQ[r_winner]) begin
            w_gnt_nxt   = 2'b00;
            w_nhalt_nxt = 1'b1;
            w_state_nxt = ST_RELEASE;
          end
`ifdef ARB_WATCHDOG_EN
          else if (r_wd_cnt == WD_W'(MAX_GRANT - 1)) begin
            w_gnt_nxt     = 2'b00;
            w_nhalt_nxt   = 1'b1;
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ST_RELEASE;
          end else begin
            w_wd_cnt_nxt  = r_wd_cnt + WD_W'(1);
          end
`endif
        end

        ST_RELEASE: begin
          w_nhalt_nxt = 1'b1;
          // Only return to IDLE once the CPU has actually taken the bus back.
          if (!BA) begin
            w_state_nxt = ST_IDLE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_nhalt_nxt = 1'b1;
          w_gnt_nxt   = 2'b00;
        end
      endcase
    end
  end

  assign nHALT       = r_nhalt;
  assign GNT         = r_gnt;
  assign o_dbg_state = r_state;

`ifdef ARB_WATCHDOG_EN
  assign TIMEOUT = r_timeout;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/mc6809e_bus_arbiter.md
# mc6809e_bus_arbiter

Clock-enable generator and DMA bus arbiter for the MC6809E core.
- Derives the CE_E_FALL / CE_Q_FALL strobes from CLK_ROOT.
- Shares the CPU bus between the core and two DMA requesters. To take the bus it asserts nHALT, waits for the halt acknowledge (BA=1, BS=1), then grants one requester.
- Sits beside the CPU wrapper. Drives the CPU's clock-enable and nHALT inputs, and the bus-owner select used by the address/data muxes.

## Interface
- QDIV, 4: CLK_ROOT cycles per quarter E phase. Legal range ≥1. E period = 4*QDIV CLK_ROOT cycles.
- MAX_GRANT, 64: watchdog limit, in E periods, on a single grant. Only used with ARB_WATCHDOG_EN.
- CLK_ROOT  in  1  single system clock. All logic is rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- CE_E_FALL  out  1  one-CLK_ROOT strobe per E period, marking E falling.
- CE_Q_FALL  out  1  one-CLK_ROOT strobe per E period, QDIV cycles before CE_E_FALL.
- BA  in  1  CPU bus available.
- BS  in  1  CPU bus status.
- nHALT  out  1  to CPU, active-low halt request.
- REQ  in  2  DMA bus requests, level, active-high.
- GNT  out  2  grants, one-hot or zero.
- TIMEOUT  out  1  one-CLK_ROOT pulse when the watchdog revokes a grant. Tied 0 without ARB_WATCHDOG_EN.

## Operation
- Phase generator:
  - sub counter 0..QDIV-1 and quarter counter 0..3, both wrapping.
  - CE_Q_FALL=1 when quarter==2 and sub==QDIV-1.
  - CE_E_FALL=1 when quarter==3 and sub==QDIV-1.
  - The strobes are combinational decodes of registered counters, so they are never high in the same cycle.
- Arbiter FSM. It advances only in cycles where CE_E_FALL=1; in all other cycles the state holds.
  - IDLE: nHALT=1, GNT=0. If REQ≠0, pick a winner, drive nHALT=0 and go to HALT_REQ.
  - Winner selection: round-robin. The requester other than `last` has priority; if only one requests, it wins. `last` resets to 1, so REQ[0] wins first after reset.
  - HALT_REQ: wait for BA=1 and BS=1.
    - If REQ[winner]=1: set GNT[winner]=1, `last`=winner, and go to GRANT.
    - If REQ[winner]=0 (request withdrawn): go to RELEASE with no grant.
  - GRANT: GNT held. If REQ[winner]=0: clear GNT, drive nHALT=1, go to RELEASE.
  - RELEASE: nHALT=1. Wait for BA=0, then go to IDLE.
- The CPU always gets at least one E period between two grants, because IDLE is mandatory.
- REQ changes outside HALT_REQ and GRANT are ignored until the next IDLE sample.
- Reset at any point: state=IDLE, nHALT=1, GNT=0, TIMEOUT=0, counters=0, `last`=1. No partial grant survives.

## Timing
- Reset values:
  - CE_E_FALL=0, CE_Q_FALL=0.
  - First CE_Q_FALL in cycle 3*QDIV-1 after reset release; first CE_E_FALL in cycle 4*QDIV-1.
- Every FSM output is registered and changes on the CLK_ROOT edge that ends a CE_E_FALL cycle.
- Latency from REQ to nHALT low: at most 1 E period plus 1 CLK_ROOT.
- Latency from halt acknowledge to GNT: BA/BS are sampled only at CE_E_FALL; GNT rises at the end of that cycle.
- Release: GNT and nHALT deassert on the same edge.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A counter of width clog2(MAX_GRANT+1) clears on entry to GRANT and increments on each CE_E_FALL in GRANT.
  - When a CE_E_FALL occurs with count==MAX_GRANT-1: GNT is cleared, nHALT=1, state goes to RELEASE, and TIMEOUT pulses for exactly that edge's following cycle.
  - The revoked requester becomes `last`, so on the next arbitration the other requester wins if both request.
- ARB_WATCHDOG_EN undefined: no counter; TIMEOUT=0; a grant lasts until REQ drops.

## Test plan
- Reset/phase (QDIV=4): release RESET. Required: CE_Q_FALL at cycles 11, 27, …; CE_E_FALL at 15, 31, …; nHALT=1 and GNT=00 throughout.
- Single request: REQ=01, CPU model raises BA=BS=1 two E periods after nHALT falls. Required: GNT=01 at that CE_E_FALL edge. Then drop REQ: GNT=00 and nHALT=1 on the same edge, and IDLE only after BA=0.
- Contention: hold REQ=11 continuously. Required: grants alternate 01, 10, 01; each grant is separated by a RELEASE→IDLE pass with nHALT high for ≥1 E period.
- Withdrawal: REQ=10 dropped to 00 while in HALT_REQ. Required: no GNT pulse; nHALT returns high at the acknowledge sample.
- Watchdog (ARB_WATCHDOG_EN, MAX_GRANT=4): hold REQ=01. Required: GNT=01 for exactly 4 E periods, then GNT=00 with a single-cycle TIMEOUT pulse. With REQ=11 the next grant goes to 10.
- Reset mid-grant: assert RESET asynchronously while GNT=10. Required: GNT=00 and nHALT=1 immediately, without waiting for a clock edge; after release the first winner is REQ[0].
